// File: rtl/audio_note_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : audio_note_scheduler
//  Purpose  : Memory-mapped tone sequencer. Note commands (duration in ticks,
//             half-period in prescaler units) are queued in a small FIFO and
//             played back to back as a square wave on the PWM duty input.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk           system clock, single domain
//    i_rst_n         asynchronous reset, active low
//    i_cmd_valid     write strobe from the IO decode
//    i_cmd_data      [31:16] duration in ticks, [15:0] half-period (0 = rest)
//    o_cmd_ready     FIFO not full; a push happens only on valid && ready
//    i_flush         drop all queued notes and abort the current note
//    i_volume        duty value driven during the high phase of the tone
//    o_duty_cycle    registered duty value to the PWM serializer
//    o_audio_enable  1 while a note is playing
//    o_busy          1 while the sequencer is active or notes are queued
//    o_fifo_count    number of queued commands, 0..DEPTH
//    o_note_done     one-cycle pulse when a note finishes
// ============================================================================
module audio_note_scheduler #(
    parameter int DEPTH          = 8,
    parameter int TICK_DIV       = 50000,
    parameter int PRESCALE_SHIFT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    input  logic [31:0]              i_cmd_data,
    output logic                     o_cmd_ready,
    input  logic                     i_flush,
    input  logic [9:0]               i_volume,
    output logic [9:0]               o_duty_cycle,
    output logic                     o_audio_enable,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_note_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = PRESCALE_SHIFT + 1;

    localparam logic [CW-1:0] c_FULL     = CW'(DEPTH);
    localparam logic [TW-1:0] c_TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] c_PRE_MAX  = PW'((1 << PRESCALE_SHIFT) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head;

    state_t        r_state;
    logic [15:0]   r_dur;
    logic [15:0]   r_half_reload;
    logic [15:0]   r_half_cnt;
    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_tick;
    logic          r_phase;
    logic [9:0]    r_duty;
    logic          r_audio_en;
    logic          r_busy;
    logic          r_note_done;

    logic          w_tone_toggle;
    logic          w_phase_nxt;
    logic [9:0]    w_play_duty;

    assign o_cmd_ready = (r_count != c_FULL);
    // flush wins over a concurrent push; LOAD always consumes the head entry
    assign w_push      = i_cmd_valid && o_cmd_ready && !i_flush;
    assign w_pop       = (r_state == S_LOAD) && !i_flush;
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cmd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tone phase look-ahead: the duty register is loaded with the value
    // that matches the phase after this edge.
    // ------------------------------------------------------------------
    assign w_tone_toggle = (r_half_reload != 16'd0) && (r_pre == c_PRE_MAX) &&
                           (r_half_cnt == 16'd1);
    assign w_phase_nxt   = r_phase ^ w_tone_toggle;
    assign w_play_duty   = ((r_half_reload != 16'd0) && w_phase_nxt) ? i_volume : 10'd0;

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_dur         <= '0;
            r_half_reload <= '0;
            r_half_cnt    <= '0;
            r_pre         <= '0;
            r_tick        <= '0;
            r_phase       <= 1'b1;
            r_duty        <= '0;
            r_audio_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_note_done   <= 1'b0;
        end else begin
            r_note_done <= 1'b0;
            if (i_flush) begin
                r_state       <= S_IDLE;
                r_dur         <= '0;
                r_half_reload <= '0;
                r_half_cnt    <= '0;
                r_pre         <= '0;
                r_tick        <= '0;
                r_phase       <= 1'b1;
                r_duty        <= '0;
                r_audio_en    <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_duty     <= '0;
                        r_audio_en <= 1'b0;
                        if (r_count != '0) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= (w_count_nxt != '0);
                        end
                    end

                    S_LOAD: begin
                        r_dur         <= w_head[31:16];
                        r_half_reload <= w_head[15:0];
                        r_half_cnt    <= w_head[15:0];
                        r_pre         <= '0;
                        r_tick        <= '0;
                        r_phase       <= 1'b1;
                        if (w_head[31:16] != 16'd0) begin
                            r_state    <= S_PLAY;
                            r_audio_en <= 1'b1;
                            r_busy     <= 1'b1;
                            r_duty     <= (w_head[15:0] != 16'd0) ? i_volume : 10'd0;
                        end else begin
                            // zero-duration note completes without playing
                            r_note_done <= 1'b1;
                            r_audio_en  <= 1'b0;
                            r_duty      <= '0;
                            // the head is being popped, so "more queued" means count > 1
                            if (r_count > CW'(1)) begin
                                r_state <= S_LOAD;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= (w_count_nxt != '0);
                            end
                        end
                    end

                    S_PLAY: begin
                        // rests leave the tone counters frozen
                        if (r_half_reload != 16'd0) begin
                            if (r_pre == c_PRE_MAX) begin
                                r_pre <= '0;
                                if (r_half_cnt == 16'd1) begin
                                    r_half_cnt <= r_half_reload;
                                end else begin
                                    r_half_cnt <= r_half_cnt - 16'd1;
                                end
                            end else begin
                                r_pre <= r_pre + PW'(1);
                            end
                        end
                        r_phase <= w_phase_nxt;

                        if ((r_tick == c_TICK_MAX) && (r_dur == 16'd1)) begin
                            r_tick      <= '0;
                            r_dur       <= '0;
                            r_note_done <= 1'b1;
                            r_audio_en  <= 1'b0;
                            r_duty      <= '0;
                            if (r_count != '0) begin
                                r_state <= S_LOAD;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= (w_count_nxt != '0);
                            end
                        end else begin
                            if (r_tick == c_TICK_MAX) begin
                                r_tick <= '0;
                                r_dur  <= r_dur - 16'd1;
                            end else begin
                                r_tick <= r_tick + TW'(1);
                            end
                            r_state    <= S_PLAY;
                            r_audio_en <= 1'b1;
                            r_busy     <= 1'b1;
                            r_duty     <= w_play_duty;
                        end
                    end

                    default: begin
                        r_state    <= S_IDLE;
                        r_duty     <= '0;
                        r_audio_en <= 1'b0;
                        r_busy     <= (w_count_nxt != '0);
                    end
                endcase
            end
        end
    end

    assign o_duty_cycle   = r_duty;
    assign o_audio_enable = r_audio_en;
    assign o_busy         = r_busy;
    assign o_fifo_count   = r_count;
    assign o_note_done    = r_note_done;

endmodule
`default_nettype wire
